dmem_arbiter: RTL and testbench

//  Two-master arbiter sharing the single Data Memory port (256-bit line bus) between ICache (m0) and DCache (m1).

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two cache memory ports, the arbiter and Data_Memory.
// Signal suffixes are from the arbiter's point of view; the slave modport is the arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              m0_enable_i;
  logic              m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic [DATA_W-1:0] m0_data_o;
  logic              m0_ack_o;

  logic              m1_enable_i;
  logic              m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic [DATA_W-1:0] m1_data_o;
  logic              m1_ack_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o,
    input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o,
    output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter (ICache = m0, DCache = m1) for the single Data_Memory line port.
// One transaction per grant; round-robin or fixed priority; sticky watchdog on a silent memory.
module dmem_arbiter #(
  parameter bit RR          = 1'b1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic           timeout_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

  logic [0:0]      state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic            timeout_q, timeout_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic busy;
  logic gnt_en;
  logic pick;

  assign busy   = (state_q == BUSY);
  assign gnt_en = grant_q ? bus.m1_enable_i : bus.m0_enable_i;
  // On a tie the master that did not go last wins under RR; otherwise ICache wins.
  assign pick   = (bus.m0_enable_i && bus.m1_enable_i) ? (RR ? ~last_q : 1'b0)
                                                       : bus.m1_enable_i;

  assign bus.mem_enable_o = busy & gnt_en;
  assign bus.mem_write_o  = busy & (grant_q ? bus.m1_write_i : bus.m0_write_i);
  assign bus.mem_addr_o   = busy ? (grant_q ? bus.m1_addr_i : bus.m0_addr_i) : '0;
  assign bus.mem_data_o   = busy ? (grant_q ? bus.m1_data_i : bus.m0_data_i) : '0;

  assign bus.m0_ack_o  = bus.mem_ack_i & busy & ~grant_q;
  assign bus.m1_ack_o  = bus.mem_ack_i & busy &  grant_q;
  assign bus.m0_data_o = bus.mem_data_i;
  assign bus.m1_data_o = bus.mem_data_i;
  assign timeout_o     = timeout_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      if (bus.m0_enable_i || bus.m1_enable_i) begin
        state_d = BUSY;
        grant_d = pick;
        last_d  = pick;
        wdog_d  = '0;
      end
    end else if (bus.mem_ack_i) begin
      state_d = IDLE;
    end else begin
      // A granted master dropping its enable abandons the transaction without an ack.
      if (!gnt_en) state_d = IDLE;
      if (wdog_q != WD_LAST) wdog_d = wdog_q + WD_W'(1);
      if (TIMEOUT_CYC != 0 && wdog_q == WD_LAST) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner sequences,
// then random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int TB_TC = 8;
  localparam logic [31:0]  A0    = 32'h0000_0040;
  localparam logic [31:0]  W1    = 32'h0000_1000;
  localparam logic [31:0]  R1    = 32'h0000_2000;
  localparam logic [255:0] LINE0 = {8{32'h0123_4567}};
  localparam logic [255:0] LINE1 = {8{32'h89AB_CDEF}};

  typedef struct {
    logic         m0_en, m0_wr;
    logic [31:0]  m0_addr;
    logic [255:0] m0_data;
    logic         m1_en, m1_wr;
    logic [31:0]  m1_addr;
    logic [255:0] m1_data;
    logic [255:0] mem_data;
    logic         ack;
  } in_t;

  typedef struct {
    logic         en, wr;
    logic [31:0]  addr;
    logic [255:0] data, d0, d1;
    logic         a0, a1, to;
  } obs_t;

  typedef struct {
    bit  fx;
    in_t v;
    int  sel;
    bit  en, a0, a1;
  } row_t;

  logic clk;
  logic rst_i;
  logic to_rr, to_fx;
  in_t  in_rr, in_fx;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if if_rr ();
  dmem_arbiter_if if_fx ();

  dmem_arbiter #(.RR(1'b1), .TIMEOUT_CYC(TB_TC)) u_rr (
    .clk_i(clk), .rst_i(rst_i), .bus(if_rr), .timeout_o(to_rr));
  dmem_arbiter #(.RR(1'b0), .TIMEOUT_CYC(0)) u_fx (
    .clk_i(clk), .rst_i(rst_i), .bus(if_fx), .timeout_o(to_fx));

  assign if_rr.m0_enable_i = in_rr.m0_en;
  assign if_rr.m0_write_i  = in_rr.m0_wr;
  assign if_rr.m0_addr_i   = in_rr.m0_addr;
  assign if_rr.m0_data_i   = in_rr.m0_data;
  assign if_rr.m1_enable_i = in_rr.m1_en;
  assign if_rr.m1_write_i  = in_rr.m1_wr;
  assign if_rr.m1_addr_i   = in_rr.m1_addr;
  assign if_rr.m1_data_i   = in_rr.m1_data;
  assign if_rr.mem_data_i  = in_rr.mem_data;
  assign if_rr.mem_ack_i   = in_rr.ack;

  assign if_fx.m0_enable_i = in_fx.m0_en;
  assign if_fx.m0_write_i  = in_fx.m0_wr;
  assign if_fx.m0_addr_i   = in_fx.m0_addr;
  assign if_fx.m0_data_i   = in_fx.m0_data;
  assign if_fx.m1_enable_i = in_fx.m1_en;
  assign if_fx.m1_write_i  = in_fx.m1_wr;
  assign if_fx.m1_addr_i   = in_fx.m1_addr;
  assign if_fx.m1_data_i   = in_fx.m1_data;
  assign if_fx.mem_data_i  = in_fx.mem_data;
  assign if_fx.mem_ack_i   = in_fx.ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic in_t mk(bit m0e, bit m0w, logic [31:0] m0a,
                             bit m1e, bit m1w, logic [31:0] m1a, bit ack);
    in_t v;
    v.m0_en = m0e; v.m0_wr = m0w; v.m0_addr = m0a; v.m0_data = LINE0;
    v.m1_en = m1e; v.m1_wr = m1w; v.m1_addr = m1a; v.m1_data = LINE1;
    v.mem_data = rnd_line();
    v.ack = ack;
    return v;
  endfunction

  function automatic row_t rw(bit fx, bit m0e, bit m0w, logic [31:0] m0a,
                              bit m1e, bit m1w, logic [31:0] m1a, bit ack,
                              int sel, bit en, bit a0, bit a1);
    row_t r;
    r.fx = fx; r.v = mk(m0e, m0w, m0a, m1e, m1w, m1a, ack);
    r.sel = sel; r.en = en; r.a0 = a0; r.a1 = a1;
    return r;
  endfunction

  function automatic obs_t get_obs(input bit fx);
    obs_t o;
    if (fx) begin
      o.en = if_fx.mem_enable_o; o.wr = if_fx.mem_write_o; o.addr = if_fx.mem_addr_o;
      o.data = if_fx.mem_data_o; o.d0 = if_fx.m0_data_o; o.d1 = if_fx.m1_data_o;
      o.a0 = if_fx.m0_ack_o; o.a1 = if_fx.m1_ack_o; o.to = to_fx;
    end else begin
      o.en = if_rr.mem_enable_o; o.wr = if_rr.mem_write_o; o.addr = if_rr.mem_addr_o;
      o.data = if_rr.mem_data_o; o.d0 = if_rr.m0_data_o; o.d1 = if_rr.m1_data_o;
      o.a0 = if_rr.m0_ack_o; o.a1 = if_rr.m1_ack_o; o.to = to_rr;
    end
    return o;
  endfunction

  task automatic drive(input bit fx, input in_t v);
    if (fx) in_fx = v;
    else    in_rr = v;
  endtask

  // One clock cycle: drive, sample on the falling edge, compare, advance past the rising edge.
  // sel: 0/1 = that master's fields expected on the memory bus, 2 = bus idle (all zero).
  task automatic cyc(input string tag, input bit fx, input in_t v, input int sel,
                     input bit en, input bit a0, input bit a1, input bit to);
    obs_t         o;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [255:0] e_data;
    drive(fx, v);
    @(negedge clk);
    o = get_obs(fx);
    case (sel)
      0:       begin e_wr = v.m0_wr; e_addr = v.m0_addr; e_data = v.m0_data; end
      1:       begin e_wr = v.m1_wr; e_addr = v.m1_addr; e_data = v.m1_data; end
      default: begin e_wr = 1'b0;    e_addr = '0;        e_data = '0;        end
    endcase
    check({tag, ".mem_en"},   256'(o.en),   256'(en));
    check({tag, ".mem_wr"},   256'(o.wr),   256'(e_wr));
    check({tag, ".mem_addr"}, 256'(o.addr), 256'(e_addr));
    check({tag, ".mem_data"}, o.data,       e_data);
    check({tag, ".m0_ack"},   256'(o.a0),   256'(a0));
    check({tag, ".m1_ack"},   256'(o.a1),   256'(a1));
    check({tag, ".m0_data"},  o.d0,         v.mem_data);
    check({tag, ".m1_data"},  o.d1,         v.mem_data);
    check({tag, ".timeout"},  256'(o.to),   256'(to));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    in_rr = mk(0, 0, '0, 0, 0, '0, 0);
    in_fx = mk(0, 0, '0, 0, 0, '0, 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  row_t tbl[$];

  initial begin
    obs_t o;
    in_t  v;
    int   owner, prev, age;
    bit   to_m;
    bit   req[2];
    bit   wr[2];
    logic [31:0]  ad[2];
    logic [255:0] dt[2];
    bit   ack, acked;

    // Vector table: RR instance (ties, writeback then refill, abort, stray ack), then fixed priority.
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 1, 0, 1,1,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 1, 1,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 1, 1, 1,0,1));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 1, 0, 1,1,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 1, 1,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 1, 1, 1,0,1));
    tbl.push_back(rw(0, 0,0,A0, 1,1,W1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,1,W1, 0, 1, 1,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,1,W1, 1, 1, 1,0,1));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 1, 0, 1,1,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 0, 1, 1,0,0));
    tbl.push_back(rw(0, 1,0,A0, 1,0,R1, 1, 1, 1,0,1));
    tbl.push_back(rw(0, 1,0,A0, 0,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 1,0,A0, 0,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(0, 0,0,A0, 0,0,R1, 0, 0, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 0,0,R1, 1, 2, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 0,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 0, 1, 1,0,0));
    tbl.push_back(rw(0, 0,0,A0, 1,0,R1, 1, 1, 1,0,1));
    tbl.push_back(rw(0, 0,0,A0, 0,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 1, 0, 1,1,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 0, 0, 1,0,0));
    tbl.push_back(rw(1, 1,0,A0, 1,0,R1, 1, 0, 1,1,0));
    tbl.push_back(rw(1, 0,0,A0, 1,0,R1, 0, 2, 0,0,0));
    tbl.push_back(rw(1, 0,0,A0, 1,0,R1, 0, 1, 1,0,0));
    tbl.push_back(rw(1, 0,0,A0, 1,0,R1, 1, 1, 1,0,1));
    tbl.push_back(rw(1, 0,0,A0, 0,0,R1, 0, 2, 0,0,0));

    // Reset state, with requests and an ack already present.
    in_rr = mk(1, 1, A0, 1, 0, R1, 1);
    in_fx = mk(0, 0, '0, 0, 0, '0, 0);
    rst_i = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    check("rst.mem_en",   256'(o.en),   '0);
    check("rst.mem_wr",   256'(o.wr),   '0);
    check("rst.mem_addr", 256'(o.addr), '0);
    check("rst.mem_data", o.data,       '0);
    check("rst.m0_ack",   256'(o.a0),   '0);
    check("rst.m1_ack",   256'(o.a1),   '0);
    check("rst.timeout",  256'(o.to),   '0);
    reset_dut();

    foreach (tbl[i]) cyc($sformatf("tbl%0d", i), tbl[i].fx, tbl[i].v,
                         tbl[i].sel, tbl[i].en, tbl[i].a0, tbl[i].a1, 1'b0);

    // m0 read acked on the tenth BUSY cycle; watchdog disabled on this instance.
    reset_dut();
    cyc("rd10.req", 1, mk(1,0,A0, 0,0,R1, 0), 2, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      cyc($sformatf("rd10.b%0d", k), 1, mk(1,0,A0, 0,0,R1, k == 10), 0, 1, k == 10, 0, 0);
    cyc("rd10.done", 1, mk(0,0,A0, 0,0,R1, 0), 2, 0, 0, 0, 0);

    // Watchdog: sets after TB_TC silent BUSY cycles, survives a late ack, cleared only by reset.
    reset_dut();
    cyc("wd.req", 0, mk(1,0,A0, 0,0,R1, 0), 2, 0, 0, 0, 0);
    for (int k = 1; k <= 11; k++)
      cyc($sformatf("wd.b%0d", k), 0, mk(1,0,A0, 0,0,R1, 0), 0, 1, 0, 0, k > TB_TC);
    cyc("wd.ack",   0, mk(1,0,A0, 0,0,R1, 1), 0, 1, 1, 0, 1);
    cyc("wd.idle",  0, mk(0,0,A0, 0,0,R1, 1), 2, 0, 0, 0, 1);
    cyc("wd.idle2", 0, mk(0,0,A0, 0,0,R1, 0), 2, 0, 0, 0, 1);
    reset_dut();
    cyc("wd.clr",   0, mk(0,0,A0, 0,0,R1, 0), 2, 0, 0, 0, 0);

    // Reset asserted mid-BUSY while memory acks: outputs drop at once, m1 re-granted afterwards.
    cyc("mr.req",  0, mk(0,0,A0, 1,0,R1, 0), 2, 0, 0, 0, 0);
    cyc("mr.busy", 0, mk(0,0,A0, 1,0,R1, 0), 1, 1, 0, 0, 0);
    drive(0, mk(0,0,A0, 1,0,R1, 1));
    #1 rst_i = 1'b0;
    #1 o = get_obs(0);
    check("mr.mem_en",   256'(o.en),   '0);
    check("mr.mem_addr", 256'(o.addr), '0);
    check("mr.m0_ack",   256'(o.a0),   '0);
    check("mr.m1_ack",   256'(o.a1),   '0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    cyc("mr.idle", 0, mk(0,0,A0, 1,0,R1, 0), 2, 0, 0, 0, 0);
    cyc("mr.regr", 0, mk(0,0,A0, 1,0,R1, 0), 1, 1, 0, 0, 0);
    cyc("mr.ack",  0, mk(0,0,A0, 1,0,R1, 1), 1, 1, 0, 1, 0);

    // Random traffic against a transaction-level model of the RR instance.
    reset_dut();
    owner = -1; prev = 1; age = 0; to_m = 1'b0;
    for (int m = 0; m < 2; m++) begin req[m] = 0; wr[m] = 0; ad[m] = '0; dt[m] = '0; end
    for (int c = 0; c < 2000; c++) begin
      if (c % 500 == 499) begin
        rst_i = 1'b0;
        #1 rst_i = 1'b1;
        owner = -1; prev = 1; to_m = 1'b0;
      end
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(2) == 0) begin
            req[m] = 1; wr[m] = 1'($urandom_range(1)); ad[m] = $urandom(); dt[m] = rnd_line();
          end
        end else if (owner == m && $urandom_range(19) == 0) begin
          req[m] = 0;
        end
      end
      ack = (owner >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      v = mk(req[0], wr[0], ad[0], req[1], wr[1], ad[1], ack);
      v.m0_data = dt[0];
      v.m1_data = dt[1];
      cyc("rand", 0, v, (owner < 0) ? 2 : owner, (owner >= 0) && req[owner],
          (owner == 0) && ack, (owner == 1) && ack, to_m);
      if (owner < 0) begin
        if (req[0] || req[1]) begin
          owner = (req[0] && req[1]) ? 1 - prev : (req[0] ? 0 : 1);
          prev  = owner;
          age   = 0;
        end
      end else if (ack) begin
        acked = $urandom_range(1) == 1;
        if (acked) req[owner] = 0;
        else begin
          req[owner] = 1; wr[owner] = 1'($urandom_range(1));
          ad[owner] = $urandom(); dt[owner] = rnd_line();
        end
        owner = -1;
      end else begin
        age++;
        if (age == TB_TC) to_m = 1'b1;
        if (!req[owner]) owner = -1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
